// File: rtl/vocab_matcher.sv
// Searches a packed list of NUL-terminated vocabulary entries in an external SRAM
// for a NUL-terminated word held in a second SRAM; exact or prefix match.
module vocab_matcher #(
    parameter int DATA_WIDTH       = 8,
    parameter int VOCAB_ADDR_WIDTH = 8,
    parameter int INPUT_ADDR_WIDTH = 4,
    parameter int IDX_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        prefix_mode,
    input  logic [VOCAB_ADDR_WIDTH-1:0] base_addr,
    input  logic [VOCAB_ADDR_WIDTH-1:0] limit_addr,
    output logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr,
    input  logic [DATA_WIDTH-1:0]       vocab_dout,
    output logic [INPUT_ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]       in_dout,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [IDX_WIDTH-1:0]        match_idx,
    output logic [VOCAB_ADDR_WIDTH-1:0] match_addr,
    output logic                        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_CMP     = 3'd2;
    localparam logic [2:0] S_SKIP_RD = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]                  state;
    logic [VOCAB_ADDR_WIDTH-1:0] av;
    logic [VOCAB_ADDR_WIDTH-1:0] av_inc;
    logic [VOCAB_ADDR_WIDTH-1:0] entry;
    logic [VOCAB_ADDR_WIDTH-1:0] limit_q;
    logic [INPUT_ADDR_WIDTH-1:0] ai;
    logic [IDX_WIDTH-1:0]        idx;
    logic                        prefix_q;

    logic vd_zero;
    logic id_zero;
    logic chars_eq;
    logic at_limit;
    logic ai_first;
    logic ai_last;

    assign av_inc   = av + VOCAB_ADDR_WIDTH'(1);
    assign at_limit = (av_inc == limit_q);
    assign vd_zero  = (vocab_dout == '0);
    assign id_zero  = (in_dout == '0);
    assign chars_eq = (vocab_dout == in_dout);
    assign ai_first = (ai == '0);
    assign ai_last  = &ai;

    assign vocab_addr = av;
    assign in_addr    = ai;
    assign done       = (state == S_FIN);
    assign busy       = (state == S_RD) || (state == S_CMP) ||
                        (state == S_SKIP_RD) || (state == S_SKIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            av         <= '0;
            ai         <= '0;
            idx        <= '0;
            entry      <= '0;
            limit_q    <= '0;
            prefix_q   <= 1'b0;
            found      <= 1'b0;
            err        <= 1'b0;
            match_idx  <= '0;
            match_addr <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        av         <= base_addr;
                        entry      <= base_addr;
                        limit_q    <= limit_addr;
                        prefix_q   <= prefix_mode;
                        ai         <= '0;
                        idx        <= '0;
                        found      <= 1'b0;
                        err        <= 1'b0;
                        match_idx  <= '0;
                        match_addr <= '0;
                        // An empty window finishes without touching the SRAM.
                        state      <= (base_addr >= limit_addr) ? S_FIN : S_RD;
                    end
                end
                S_RD: state <= S_CMP;
                S_CMP: begin
                    if (id_zero && (vd_zero || prefix_q)) begin
                        found      <= 1'b1;
                        match_idx  <= idx;
                        match_addr <= entry;
                        state      <= S_FIN;
                    end else if (ai_first && vd_zero) begin
                        state <= S_FIN;
                    end else if (chars_eq) begin
                        if (at_limit) begin
                            state <= S_FIN;
                        end else if (ai_last) begin
                            err   <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            av    <= av_inc;
                            ai    <= ai + INPUT_ADDR_WIDTH'(1);
                            state <= S_RD;
                        end
                    end else if (vd_zero) begin
                        if (at_limit) begin
                            state <= S_FIN;
                        end else begin
                            av    <= av_inc;
                            entry <= av_inc;
                            idx   <= idx + IDX_WIDTH'(1);
                            ai    <= '0;
                            state <= S_RD;
                        end
                    end else if (at_limit) begin
                        state <= S_FIN;
                    end else begin
                        av    <= av_inc;
                        state <= S_SKIP_RD;
                    end
                end
                S_SKIP_RD: state <= S_SKIP;
                S_SKIP: begin
                    // Scan to the terminator of a rejected entry, then restart matching.
                    if (at_limit) begin
                        state <= S_FIN;
                    end else if (vd_zero) begin
                        av    <= av_inc;
                        entry <= av_inc;
                        idx   <= idx + IDX_WIDTH'(1);
                        ai    <= '0;
                        state <= S_RD;
                    end else begin
                        av    <= av_inc;
                        state <= S_SKIP_RD;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vocab_matcher.sv
// Bench for vocab_matcher: SRAM models, a string-walk reference model, directed
// cases with literal expectations and randomized vocabularies.
module tb_vocab_matcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       prefix_mode;
    logic [7:0] base_addr;
    logic [7:0] limit_addr;
    logic [7:0] vocab_addr;
    logic [7:0] vocab_dout;
    logic [3:0] in_addr;
    logic [7:0] in_dout;
    logic       busy;
    logic       done;
    logic       found;
    logic [7:0] match_idx;
    logic [7:0] match_addr;
    logic       err;

    logic [7:0] vmem [256];
    logic [7:0] imem [16];

    int total = 0;
    int bad = 0;
    int cur_limit = 256;
    bit in_run = 1'b0;
    logic prev_done = 1'b0;

    int r_found, r_idx, r_addr, r_err, r_lat;

    vocab_matcher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .prefix_mode(prefix_mode), .base_addr(base_addr), .limit_addr(limit_addr),
        .vocab_addr(vocab_addr), .vocab_dout(vocab_dout),
        .in_addr(in_addr), .in_dout(in_dout),
        .busy(busy), .done(done), .found(found), .match_idx(match_idx),
        .match_addr(match_addr), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vocab_dout <= vmem[vocab_addr];
        in_dout    <= imem[in_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle invariants while a search is in flight.
    always @(negedge clk) begin
        if (rst_n && in_run) begin
            check("cycle_window", int'(busy && (int'(vocab_addr) >= cur_limit)), 0);
            check("cycle_done_pulse", int'((done && prev_done) || (busy && done)), 0);
        end
        prev_done <= done;
    end

    // Reference: walk entries as strings; count every vocab character read.
    function automatic void model(input int base, input int limit, input bit pm,
                                  output bit f, output int idx_o, output int addr_o,
                                  output bit e, output int reads);
        int p, k, a, idx;
        logic [7:0] vd, id;
        f = 0; idx_o = 0; addr_o = 0; e = 0; reads = 0;
        if (base >= limit) return;
        p = base; idx = 0; k = 0;
        while (1) begin
            a = p + k;
            reads++;
            vd = vmem[a];
            id = imem[k];
            if (id == 0 && (vd == 0 || pm)) begin
                f = 1; idx_o = idx % 256; addr_o = p;
                return;
            end
            if (k == 0 && vd == 0) return;
            if (vd == id) begin
                if (a + 1 == limit) return;
                if (k == 15) begin e = 1; return; end
                k++;
            end else begin
                while (vd != 0) begin
                    a++;
                    if (a == limit) return;
                    reads++;
                    vd = vmem[a];
                end
                p = a + 1;
                if (p == limit) return;
                idx++;
                k = 0;
            end
        end
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) vmem[i] = 8'd0;
        for (int i = 0; i < 16; i++) imem[i] = 8'd0;
    endtask

    task automatic put_word(input string w, input int at);
        for (int i = 0; i < w.len(); i++) vmem[at + i] = w[i];
        vmem[at + w.len()] = 8'd0;
    endtask

    task automatic set_input(input string w);
        for (int i = 0; i < 16; i++) imem[i] = 8'd0;
        for (int i = 0; i < w.len(); i++) imem[i] = w[i];
    endtask

    task automatic run(input int base, input int limit, input bit pm, input bit poke,
                       input string name);
        bit ef, ee;
        int ei, ea, er, c;
        model(base, limit, pm, ef, ei, ea, ee, er);
        cur_limit = limit;
        @(negedge clk);
        base_addr = 8'(base); limit_addr = 8'(limit); prefix_mode = pm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 8'($urandom); limit_addr = 8'($urandom); prefix_mode = 1'($urandom);
        in_run = 1'b1;
        c = 1;
        while (!done && c < 3000) begin
            check({name, "_busy"}, int'(busy), 1);
            start = (poke && c == 3);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        in_run = 1'b0;
        check({name, "_done"}, int'(done), 1);
        check({name, "_latency"}, c, 2 * er + 1);
        check({name, "_busy_at_done"}, int'(busy), 0);
        check({name, "_found"}, int'(found), int'(ef));
        check({name, "_idx"}, int'(match_idx), ei);
        check({name, "_addr"}, int'(match_addr), ea);
        check({name, "_err"}, int'(err), int'(ee));
        r_found = found; r_idx = match_idx; r_addr = match_addr; r_err = err; r_lat = c;
    endtask

    initial begin
        int p, nw, sel, wi, len, base, limit, c;
        int ws [16];
        int wl [16];
        bit ef, ee;
        int ei, ea, er;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; prefix_mode = 1'b0;
        base_addr = 8'd0; limit_addr = 8'd0;
        clear_mems();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_found", int'(found), 0);
        check("reset_vaddr", int'(vocab_addr), 0);
        check("reset_iaddr", int'(in_addr), 0);
        check("reset_idx", int'(match_idx), 0);
        check("reset_maddr", int'(match_addr), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // "cat\0dog\0\0", exact search for "dog"
        put_word("cat", 0); put_word("dog", 4);
        set_input("dog");
        run(0, 255, 0, 0, "dog");
        check("pin_dog_found", r_found, 1);
        check("pin_dog_idx", r_idx, 1);
        check("pin_dog_addr", r_addr, 4);
        check("pin_dog_lat", r_lat, 17);

        set_input("cow");
        run(0, 255, 0, 1, "cow");
        check("pin_cow_found", r_found, 0);
        check("pin_cow_err", r_err, 0);
        check("pin_cow_lat", r_lat, 19);

        set_input("dog");
        run(0, 6, 0, 0, "limit6");
        check("pin_limit_found", r_found, 0);
        check("pin_limit_lat", r_lat, 13);

        run(9, 9, 0, 0, "empty_window");
        check("pin_empty_lat", r_lat, 1);

        clear_mems();
        put_word("cats", 0);
        set_input("cat");
        run(0, 255, 0, 0, "cats_exact");
        check("pin_cats_exact", r_found, 0);
        run(0, 255, 1, 0, "cats_prefix");
        check("pin_cats_prefix", r_found, 1);
        check("pin_cats_prefix_idx", r_idx, 0);

        clear_mems();
        for (int i = 0; i < 16; i++) begin
            imem[i] = 8'(97 + i % 4);
            vmem[i] = 8'(97 + i % 4);
        end
        run(0, 255, 0, 0, "no_term");
        check("pin_noterm_err", r_err, 1);
        check("pin_noterm_found", r_found, 0);

        // Abort five cycles after start, then a clean rerun.
        clear_mems();
        put_word("cat", 0); put_word("dog", 4);
        set_input("cow");
        cur_limit = 255;
        @(negedge clk);
        base_addr = 8'd0; limit_addr = 8'd255; prefix_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        c = 0;
        repeat (20) begin
            c += int'(done);
            @(negedge clk);
        end
        check("abort_no_done", c, 0);
        check("abort_found", int'(found), 0);
        check("abort_err", int'(err), 0);
        set_input("dog");
        run(0, 255, 0, 0, "after_abort");

        // Abort coinciding with start in IDLE: start takes effect.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_over_abort_busy", int'(busy), 1);
        c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("start_over_abort_done", int'(done), 1);
        check("start_over_abort_found", int'(found), 1);

        // Asynchronous reset mid-search.
        run(0, 255, 0, 0, "pre_reset");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_vaddr", int'(vocab_addr), 0);
        check("midreset_found", int'(found), 0);
        check("midreset_idx", int'(match_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            clear_mems();
            p = 0;
            nw = $urandom_range(3, 12);
            for (int w = 0; w < nw; w++) begin
                len = $urandom_range(1, 5);
                ws[w] = p; wl[w] = len;
                for (int j = 0; j < len; j++) vmem[p + j] = 8'(97 + $urandom_range(0, 3));
                p += len + 1;
            end
            sel = $urandom_range(0, 3);
            wi = $urandom_range(0, nw - 1);
            if (sel <= 1) begin
                for (int j = 0; j < wl[wi]; j++) imem[j] = vmem[ws[wi] + j];
            end else if (sel == 2) begin
                len = $urandom_range(1, wl[wi]);
                for (int j = 0; j < len; j++) imem[j] = vmem[ws[wi] + j];
            end else begin
                len = $urandom_range(1, 5);
                for (int j = 0; j < len; j++) imem[j] = 8'(97 + $urandom_range(0, 3));
            end
            base = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(0, p);
            limit = ($urandom_range(0, 9) < 6) ? 255 : $urandom_range(0, p + 1);
            model(base, limit, 1'b0, ef, ei, ea, ee, er);
            run(base, limit, 1'($urandom_range(0, 1)), (t % 5 == 0), $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
